mux_n_seq: RTL and testbench

MUX_N_SEQ -- requirements
Module: mux_n_seq

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_pick.sv | 27 ++
 rtl/mux_n_seq.sv | 76 +++++++
 tb/tb_mux_n_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and width helper for the channel mux
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Channel index width: never narrower than one bit, even for N = 2.
  function automatic int cw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, scans from ptr with wrap
module rr_pick #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    int k;
    k       = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!gnt_any && req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_n_seq.sv
// rtl/mux_n_seq.sv - N-channel to one mux with a single registered output stage
module mux_n_seq
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int CW   = cw_of(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [CW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  out_chan
);

  logic          load_en;
  logic          gnt_any;
  logic          xfer;
  logic [CW-1:0] gnt_idx;

  assign load_en = !out_valid || out_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [CW-1:0] ptr;
      logic          unused_sel;

      assign unused_sel = ^sel;

      rr_pick #(.N(N), .CW(CW)) u_pick (
        .req    (in_valid),
        .ptr    (ptr),
        .gnt_idx(gnt_idx),
        .gnt_any(gnt_any)
      );

      // Pointer only moves on an actual transfer, so a stalled grant is held.
      always_ff @(posedge clk) begin
        if (rst) begin
          ptr <= '0;
        end else if (xfer) begin
          ptr <= (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end else begin : g_fixed
      localparam logic [CW:0] N_EXT = (CW + 1)'(N);

      assign gnt_idx = sel;
      assign gnt_any = ({1'b0, sel} < N_EXT);
    end
  endgenerate

  assign in_ready = (gnt_any && load_en) ? (N'(1) << gnt_idx) : '0;
  assign xfer     = gnt_any && load_en && in_valid[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx*W +: W];
      out_chan  <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_seq.sv
// tb/tb_mux_n_seq.sv - scoreboard bench: fixed N=4, round-robin N=4, fixed N=3
module tb_mux_n_seq;

  typedef struct {
    int         chan;
    logic [7:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_a = '0;
  logic [23:0] data_c = '0;
  logic [3:0]  vld_a  = '0;
  logic [2:0]  vld_c  = '0;
  logic [1:0]  sel_a  = '0;
  logic [1:0]  sel_c  = '0;
  logic        ordy_a = 1'b0;
  logic        ordy_c = 1'b0;

  logic [3:0] rdy0, rdy1;
  logic [2:0] rdy2;
  logic [7:0] od0, od1, od2;
  logic       ov0, ov1, ov2;
  logic [1:0] oc0, oc1, oc2;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t q0[$], q1[$], q2[$];
  int    ptr_m[3];
  bit    held[3];
  bit    rst_q = 1'b1;
  int    nn[3]   = '{4, 4, 3};
  int    mode[3] = '{0, 1, 0};

  always #5 clk = ~clk;

  mux_n_seq #(.N(4), .W(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(data_a), .in_valid(vld_a), .in_ready(rdy0),
    .sel(sel_a), .out_data(od0), .out_valid(ov0), .out_ready(ordy_a), .out_chan(oc0));

  mux_n_seq #(.N(4), .W(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(data_a), .in_valid(vld_a), .in_ready(rdy1),
    .sel(sel_a), .out_data(od1), .out_valid(ov1), .out_ready(ordy_a), .out_chan(oc1));

  mux_n_seq #(.N(3), .W(8), .MODE(0)) dut2 (
    .clk(clk), .rst(rst), .in_data(data_c), .in_valid(vld_c), .in_ready(rdy2),
    .sel(sel_c), .out_data(od2), .out_valid(ov2), .out_ready(ordy_c), .out_chan(oc2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input word_t w);
    case (d)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic pop(input int d, input logic [1:0] c, input logic [7:0] dt);
    word_t w;
    int    sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      chk($sformatf("dut%0d unexpected word", d), 32'd1, 32'd0);
      return;
    end
    case (d)
      0:       w = q0.pop_front();
      1:       w = q1.pop_front();
      default: w = q2.pop_front();
    endcase
    chk($sformatf("dut%0d out_chan", d), 32'(c), 32'(w.chan));
    chk($sformatf("dut%0d out_data", d), 32'(dt), 32'(w.data));
  endtask

  // Reference grant: first valid channel from the pointer (round-robin) or sel (fixed).
  function automatic void grant(input int d, input logic [3:0] vld, input int sel,
                                output int g, output bit ok);
    ok = 1'b0;
    g  = 0;
    if (mode[d] == 0) begin
      g  = sel;
      ok = (sel < nn[d]);
    end else begin
      for (int i = 0; i < nn[d]; i++) begin
        if (!ok && vld[(ptr_m[d] + i) % nn[d]]) begin
          g  = (ptr_m[d] + i) % nn[d];
          ok = 1'b1;
        end
      end
    end
  endfunction

  task automatic model(input int d, input logic [3:0] vld, input int sel, input bit ordy,
                       input logic [3:0] rdy_act, input logic [31:0] data, input bit ov_act);
    int         g;
    bit         ok;
    logic [3:0] exp_rdy;
    word_t      w;
    chk($sformatf("dut%0d out_valid", d), 32'(ov_act), 32'(held[d]));
    grant(d, vld, sel, g, ok);
    exp_rdy = (ok && (!held[d] || ordy)) ? 4'(1 << g) : 4'b0;
    chk($sformatf("dut%0d in_ready", d), 32'(rdy_act), 32'(exp_rdy));
    if (!rst) begin
      if (exp_rdy != 0 && vld[g]) begin
        w.chan   = g;
        w.data   = data[g*8 +: 8];
        push(d, w);
        held[d]  = 1'b1;
        ptr_m[d] = (g + 1) % nn[d];
      end else if (ordy) begin
        held[d] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [3:0] va, input logic [2:0] vc, input logic [1:0] sa,
                      input logic [1:0] sc, input bit oa, input bit oc, input bit r);
    @(posedge clk);
    #1;
    if (rst_q) begin
      q0.delete(); q1.delete(); q2.delete();
      held     = '{0, 0, 0};
      ptr_m    = '{0, 0, 0};
      chk("dut0 reset data", 32'(od0), 32'd0);
      chk("dut1 reset data", 32'(od1), 32'd0);
      chk("dut1 reset chan", 32'(oc1), 32'd0);
      chk("dut2 reset data", 32'(od2), 32'd0);
    end
    rst    = r;
    vld_a  = va;
    vld_c  = vc;
    sel_a  = sa;
    sel_c  = sc;
    ordy_a = oa;
    ordy_c = oc;
    data_a = $urandom;
    data_c = 24'($urandom);
    #1;
    model(0, vld_a, int'(sel_a), ordy_a, rdy0, data_a, ov0);
    model(1, vld_a, int'(sel_a), ordy_a, rdy1, data_a, ov1);
    model(2, {1'b0, vld_c}, int'(sel_c), ordy_c, {1'b0, rdy2}, {8'h0, data_c}, ov2);
    rst_q = r;
  endtask

  always @(negedge clk) begin
    if (ov0 === 1'b1 && ordy_a) pop(0, oc0, od0);
    if (ov1 === 1'b1 && ordy_a) pop(1, oc1, od1);
    if (ov2 === 1'b1 && ordy_c) pop(2, oc2, od2);
  end

  initial begin
    step(4'b0000, 3'b000, 2'd0, 2'd3, 1'b0, 1'b1, 1'b1);
    step(4'b1111, 3'b111, 2'd0, 2'd3, 1'b1, 1'b1, 1'b1);
    // Single word from channel 2, then a 3-cycle stall while sel walks.
    step(4'b0100, 3'b111, 2'd2, 2'd3, 1'b1, 1'b1, 1'b0);
    step(4'b1111, 3'b111, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0);
    step(4'b1111, 3'b111, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0);
    step(4'b1111, 3'b111, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b1111, 3'b111, 2'(i), 2'd3, 1'b1, 1'b1, 1'b0);
    // Pointer lands on 3, then wraps to channel 0 and moves to 1.
    step(4'b0100, 3'b111, 2'd2, 2'd3, 1'b1, 1'b1, 1'b0);
    step(4'b0011, 3'b111, 2'd0, 2'd3, 1'b1, 1'b1, 1'b0);
    step(4'b0011, 3'b111, 2'd1, 2'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0010, 3'b010, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0);
    step(4'b0010, 3'b010, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0010, 3'b010, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 3'($urandom), 2'($urandom), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 3; i++) step(4'b0000, 3'b000, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("dut0 drained", 32'(q0.size()), 32'd0);
    chk("dut1 drained", 32'(q1.size()), 32'd0);
    chk("dut2 drained", 32'(q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
